// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode/dispatch controller: opcodes,
// instruction field slicing and the controller state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W          = 16;
    localparam int unsigned NUM_OPC          = 16;

    localparam logic [3:0]  OPC_MOVI         = 4'h7;
    localparam logic [3:0]  OPC_HALT_DEFAULT = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitMem,
        StDecode,
        StDispatch,
        StWaitDone,
        StHalt
    } state_e;

    // Instruction layout: [15:12] opcode, [11:6] Ri, [5:0] Rj or immediate.
    function automatic logic [3:0] instr_opc(input logic [INSTR_W-1:0] w);
        return w[15:12];
    endfunction

    function automatic logic [5:0] instr_ri(input logic [INSTR_W-1:0] w);
        return w[11:6];
    endfunction

    function automatic logic [5:0] instr_num(input logic [INSTR_W-1:0] w);
        return w[5:0];
    endfunction

endpackage

// File: rtl/dispatch_wdog.sv
// Wait-state watchdog: counts stalled cycles and flags expiry on the
// WDOG_MAX-th consecutive stalled cycle since the last clear.
module dispatch_wdog #(
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    // Expiry and next count; the counter saturates once expired.
    always_comb begin
        expire = count && (cnt_q == WDOG_W'(WDOG_MAX - 1));
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && !expire) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_dispatch.sv
// Fetch/decode/dispatch controller: fetches 16-bit instructions over a
// req/ack port, pulses one execution FSM start line and waits for its done.
module instr_dispatch
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter logic [3:0]  OPC_HALT = OPC_HALT_DEFAULT,
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                mem_req,
    output logic [PC_W-1:0]     mem_addr,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_data,
    output logic [NUM_OPC-1:0]  start_vec,
    output logic [5:0]          Ri,
    output logic [5:0]          num,
    input  logic [NUM_OPC-1:0]  done_vec,
    output logic [PC_W-1:0]     pc,
    output logic                halted,
    output logic                err
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 mem_req_q, mem_req_d;
    logic [PC_W-1:0]      mem_addr_q, mem_addr_d;
    logic [NUM_OPC-1:0]   start_vec_q, start_vec_d;
    logic [5:0]           ri_q, ri_d;
    logic [5:0]           num_q, num_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 err_q, err_d;

    logic                 wdog_clear;
    logic                 wdog_count;
    logic                 wdog_expire;
    logic [3:0]           opc;
    logic                 done_hit;

    assign opc      = instr_opc(ir_q);
    // Only the dispatched opcode's done line matters.
    assign done_hit = done_vec[opc];

    dispatch_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wdog_clear),
        .count  (wdog_count),
        .expire (wdog_expire)
    );

    // Next-state and registered-output logic for the controller FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        start_vec_d = '0;
        ri_d        = ri_q;
        num_d       = num_q;
        ir_d        = ir_q;
        err_d       = err_q;
        wdog_clear  = 1'b0;
        wdog_count  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_req_d  = 1'b1;
                mem_addr_d = pc_q;
                wdog_clear = 1'b1;
                state_d    = StWaitMem;
            end
            StWaitMem: begin
                if (mem_ack) begin
                    ir_d      = mem_data;
                    mem_req_d = 1'b0;
                    state_d   = StDecode;
                end else begin
                    wdog_count = 1'b1;
                    if (wdog_expire) begin
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = StHalt;
                    end
                end
            end
            StDecode: begin
                ri_d    = instr_ri(ir_q);
                num_d   = instr_num(ir_q);
                state_d = (opc == OPC_HALT) ? StHalt : StDispatch;
            end
            StDispatch: begin
                start_vec_d = NUM_OPC'(1) << opc;
                wdog_clear  = 1'b1;
                state_d     = StWaitDone;
            end
            StWaitDone: begin
                if (done_hit) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = run ? StFetch : StIdle;
                end else begin
                    wdog_count = 1'b1;
                    if (wdog_expire) begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            start_vec_q <= '0;
            ri_q        <= '0;
            num_q       <= '0;
            ir_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            start_vec_q <= start_vec_d;
            ri_q        <= ri_d;
            num_q       <= num_d;
            ir_q        <= ir_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign start_vec = start_vec_q;
    assign Ri        = ri_q;
    assign num       = num_q;
    assign pc        = pc_q;
    assign halted    = (state_q == StHalt);
    assign err       = err_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed testbench for instr_dispatch: hand-computed expectations per scenario.
module tb_instr_dispatch;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned WDOG_MAX = 255;

    logic            clk;
    logic            reset;
    logic            run;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [15:0]     mem_data;
    logic [15:0]     start_vec;
    logic [5:0]      ri;
    logic [5:0]      num;
    logic [15:0]     done_vec;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            err;

    int vectors;
    int miscompares;

    instr_dispatch #(
        .PC_W     (PC_W),
        .OPC_HALT (4'hF),
        .WDOG_MAX (WDOG_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .start_vec (start_vec),
        .Ri        (ri),
        .num       (num),
        .done_vec  (done_vec),
        .pc        (pc),
        .halted    (halted),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation still running at %0t, limit 1ms", $time);
        $fatal(1, "timeout");
    end

    // ---- stimulus helpers (no checking) ----
    task automatic do_reset();
        reset    = 1'b0;
        run      = 1'b0;
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        done_vec = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic give_ack(input logic [15:0] w, input int delay);
        repeat (delay) @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = w;
        @(negedge clk);
        mem_ack  = 1'b0;
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (start_vec !== 16'h0000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_done(input logic [15:0] v);
        done_vec = v;
        @(negedge clk);
        done_vec = 16'h0000;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        do_reset();
        vectors++;
        if ({mem_req, mem_addr, start_vec, ri, num, pc, halted, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: req=%b addr=%h start=%h Ri=%h num=%h pc=%h halt=%b err=%b, want all 0",
                     mem_req, mem_addr, start_vec, ri, num, pc, halted, err);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: mem_req=%b want 0 with run=0", mem_req);
        end
    endtask

    task automatic test_single_movi();
        bit ok;
        do_reset();
        run = 1'b1;
        wait_req(20, ok);
        vectors++;
        if (!ok || mem_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL t1_fetch: ok=%b addr=%h want ok=1 addr=00", ok, mem_addr);
        end
        give_ack(16'h71C5, 1);
        wait_start(20, ok);
        vectors++;
        if (!ok || start_vec !== 16'h0080 || ri !== 6'd7 || num !== 6'd5) begin
            miscompares++;
            $display("FAIL t1_start: ok=%b start=%h Ri=%0d num=%0d want 0080 Ri=7 num=5",
                     ok, start_vec, ri, num);
        end
        @(negedge clk);
        vectors++;
        if (start_vec !== 16'h0000) begin
            miscompares++;
            $display("FAIL t1_start_pulse: start=%h want 0000 one cycle later", start_vec);
        end
        @(negedge clk);
        pulse_done(16'h0080);
        vectors++;
        if (pc !== 8'h01 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_pc_adv: pc=%h req=%b want pc=01 req=0", pc, mem_req);
        end
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin
            miscompares++;
            $display("FAIL t1_refetch: req=%b addr=%h want req=1 addr=01", mem_req, mem_addr);
        end
    endtask

    task automatic test_program_halt();
        bit ok;
        int starts;
        int req_seen;
        logic [15:0] prog [3];
        logic [5:0]  exp_ri [2];
        logic [5:0]  exp_num [2];
        prog[0] = 16'h7045; exp_ri[0] = 6'd1; exp_num[0] = 6'd5;
        prog[1] = 16'h7083; exp_ri[1] = 6'd2; exp_num[1] = 6'd3;
        prog[2] = 16'hF000;
        starts = 0;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_req(20, ok);
            give_ack(prog[i], 0);
            wait_start(20, ok);
            if (ok && start_vec === 16'h0080) starts++;
            vectors++;
            if (ri !== exp_ri[i] || num !== exp_num[i]) begin
                miscompares++;
                $display("FAIL t2_fields%0d: Ri=%0d num=%0d want Ri=%0d num=%0d",
                         i, ri, num, exp_ri[i], exp_num[i]);
            end
            @(negedge clk);
            pulse_done(16'h0080);
        end
        wait_req(20, ok);
        vectors++;
        if (!ok || mem_addr !== 8'h02) begin
            miscompares++;
            $display("FAIL t2_halt_fetch: ok=%b addr=%h want ok=1 addr=02", ok, mem_addr);
        end
        give_ack(prog[2], 0);
        req_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0) req_seen++;
            if (start_vec !== 16'h0000) starts = starts + 100;
        end
        vectors++;
        if (starts !== 2) begin
            miscompares++;
            $display("FAIL t2_start_count: got %0d want 2", starts);
        end
        vectors++;
        if (halted !== 1'b1 || pc !== 8'h02 || req_seen !== 0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL t2_halted: halted=%b pc=%h req_cycles=%0d err=%b want 1 02 0 0",
                     halted, pc, req_seen, err);
        end
    endtask

    task automatic test_done_filter();
        bit ok;
        do_reset();
        run = 1'b1;
        wait_req(20, ok);
        give_ack(16'h7000, 0);
        wait_start(20, ok);
        @(negedge clk);
        pulse_done(16'h0008);
        repeat (3) @(negedge clk);
        vectors++;
        if (pc !== 8'h00 || mem_req !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_ignore_other_done: pc=%h req=%b halted=%b want 00 0 0",
                     pc, mem_req, halted);
        end
        pulse_done(16'h0080);
        vectors++;
        if (pc !== 8'h01) begin
            miscompares++;
            $display("FAIL t3_own_done: pc=%h want 01", pc);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int n;
        do_reset();
        run = 1'b1;
        wait_req(20, ok);
        n = 0;
        while (err !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n < WDOG_MAX - 2 || n > WDOG_MAX + 2) begin
            miscompares++;
            $display("FAIL t4_wdog_time: err after %0d cycles want about %0d", n, WDOG_MAX);
        end
        vectors++;
        if (err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_wdog_state: err=%b halted=%b req=%b want 1 1 0", err, halted, mem_req);
        end
        do_reset();
        vectors++;
        if (err !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_reset_clears: err=%b halted=%b want 0 0", err, halted);
        end
    endtask

    task automatic test_pc_wrap();
        bit ok1;
        bit ok2;
        int bad;
        bad = 0;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 255; i++) begin
            wait_req(20, ok1);
            give_ack(16'h7000, 0);
            wait_start(20, ok2);
            if (!ok1 || !ok2) bad++;
            pulse_done(16'h0080);
        end
        vectors++;
        if (bad != 0 || pc !== 8'hFF) begin
            miscompares++;
            $display("FAIL t5_pc_ff: timeouts=%0d pc=%h want 0 FF", bad, pc);
        end
        wait_req(20, ok1);
        vectors++;
        if (!ok1 || mem_addr !== 8'hFF) begin
            miscompares++;
            $display("FAIL t5_addr_ff: ok=%b addr=%h want 1 FF", ok1, mem_addr);
        end
        give_ack(16'h7000, 0);
        wait_start(20, ok2);
        pulse_done(16'h0080);
        vectors++;
        if (pc !== 8'h00) begin
            miscompares++;
            $display("FAIL t5_pc_wrap: pc=%h want 00", pc);
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        do_reset();
        run = 1'b1;
        wait_req(20, ok);
        give_ack(16'h7000, 0);
        wait_start(20, ok);
        pulse_done(16'h0080);
        wait_req(20, ok);
        give_ack(16'h71C5, 0);
        wait_start(20, ok);
        vectors++;
        if (!ok || pc !== 8'h01 || ri !== 6'd7) begin
            miscompares++;
            $display("FAIL t6_setup: ok=%b pc=%h Ri=%0d want 1 01 7", ok, pc, ri);
        end
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulse_done(16'h0080);
        repeat (3) @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr, start_vec, ri, num, pc, halted, err} !== '0) begin
            miscompares++;
            $display("FAIL t6_after_reset: req=%b addr=%h start=%h Ri=%h num=%h pc=%h halt=%b err=%b, want all 0",
                     mem_req, mem_addr, start_vec, ri, num, pc, halted, err);
        end
        run = 1'b1;
        wait_req(20, ok);
        vectors++;
        if (!ok || mem_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL t6_restart: ok=%b addr=%h want 1 00", ok, mem_addr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        run         = 1'b0;
        mem_ack     = 1'b0;
        mem_data    = 16'h0000;
        done_vec    = 16'h0000;
        @(negedge clk);
        test_reset();
        test_single_movi();
        test_program_halt();
        test_done_filter();
        test_watchdog();
        test_pc_wrap();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
